// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one fixed-latency divider among NREQ requesters.
// Issue is credit-gated so in-flight plus buffered results never exceed the result FIFO.
module div_scheduler #(
  parameter int NREQ  = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [24*NREQ-1:0]      req_dividend_i,
  input  logic [24*NREQ-1:0]      req_divisor_i,
  output logic [23:0]             div_dividend_o,
  output logic [23:0]             div_divisor_o,
  input  logic [13:0]             div_quotient_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [13:0]             res_quotient_o,
  output logic [$clog2(NREQ)-1:0] res_tag_o,
  output logic                    res_dz_o
);
  localparam int TW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);

  logic [TW-1:0]          last_grant_q, last_grant_d;
  logic [TW-1:0]          grant, cand;
  logic                   found, credit_ok, issue;
  logic [23:0]            sel_dividend, sel_divisor;
  int                     idx;

  logic [LAT-1:0]         sr_vld_q, sr_vld_d;
  logic [LAT-1:0][TW-1:0] sr_tag_q, sr_tag_d;
  logic [LAT-1:0]         sr_dz_q, sr_dz_d;

  logic [13:0]            q_mem   [DEPTH];
  logic [TW-1:0]          tag_mem [DEPTH];
  logic                   dz_mem  [DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   push, pop;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant = last_grant_q;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx  = (int'(last_grant_q) + i) % NREQ;
      cand = TW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == TW'(i)) begin
        sel_dividend = req_dividend_i[24*i +: 24];
        sel_divisor  = req_divisor_i[24*i +: 24];
      end
    end
  end

  // Credit uses registered count, so a pop frees its slot only from the next cycle
  assign credit_ok = (int'(cnt_q) + $countones(sr_vld_q)) < DEPTH;
  assign issue     = found && credit_ok && rst_n_i;

  always_comb begin
    req_ready_o    = '0;
    div_dividend_o = '0;
    div_divisor_o  = '0;
    last_grant_d   = last_grant_q;
    if (issue) begin
      req_ready_o[grant] = 1'b1;
      div_dividend_o     = sel_dividend;
      div_divisor_o      = sel_divisor;
      last_grant_d       = grant;
    end
  end

  always_comb begin
    sr_vld_d    = sr_vld_q;
    sr_tag_d    = sr_tag_q;
    sr_dz_d     = sr_dz_q;
    sr_vld_d[0] = issue;
    sr_tag_d[0] = grant;
    sr_dz_d[0]  = (sel_divisor == '0);
    for (int k = 1; k < LAT; k++) begin
      sr_vld_d[k] = sr_vld_q[k-1];
      sr_tag_d[k] = sr_tag_q[k-1];
      sr_dz_d[k]  = sr_dz_q[k-1];
    end
  end

  assign push = sr_vld_q[LAT-1];
  assign pop  = res_valid_o && res_ready_i;

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= TW'(NREQ - 1);
      sr_vld_q     <= '0;
      sr_tag_q     <= '0;
      sr_dz_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      sr_vld_q     <= sr_vld_d;
      sr_tag_q     <= sr_tag_d;
      sr_dz_q      <= sr_dz_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Storage needs no reset: reads are masked whenever the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_mem[wptr_q]   <= sr_dz_q[LAT-1] ? 14'd0 : div_quotient_i;
      tag_mem[wptr_q] <= sr_tag_q[LAT-1];
      dz_mem[wptr_q]  <= sr_dz_q[LAT-1];
    end
  end

  assign res_valid_o    = (cnt_q != '0);
  assign res_quotient_o = res_valid_o ? q_mem[rptr_q]   : '0;
  assign res_tag_o      = res_valid_o ? tag_mem[rptr_q] : '0;
  assign res_dz_o       = res_valid_o ? dz_mem[rptr_q]  : 1'b0;

endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler: bench-side divider plus queue-based scoreboard.
module tb_div_scheduler;
  localparam int NREQ = 4, LAT = 4, DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid = '0, req_ready;
  logic [24*NREQ-1:0]   req_dividend = '0, req_divisor = '0;
  logic [23:0]          div_dividend, div_divisor;
  logic [13:0]          div_quotient = '0, res_quotient;
  logic                 res_valid, res_dz, res_ready = 1'b0;
  logic [1:0]           res_tag;
  int                   n_cmp = 0, n_err = 0;

  div_scheduler #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_quotient_i(div_quotient),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_quotient_o(res_quotient), .res_tag_o(res_tag), .res_dz_o(res_dz)
  );

  always #5 clk = ~clk;

  // Fixed-point 1Q12 divide with saturation; divide-by-zero returns junk on purpose
  function automatic logic [13:0] fdiv(input logic [23:0] a, input logic [23:0] b);
    longint sa, sb, q;
    if (b == 24'd0) return 14'h1555;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = (sa * 4096) / sb;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return q[13:0];
  endfunction

  // Shared divider: operands seen in cycle c yield a quotient during cycle c+LAT
  logic [13:0] dpipe [0:LAT] = '{default: 14'd0};
  always @(negedge clk) begin
    for (int k = LAT; k > 0; k--) dpipe[k] = dpipe[k-1];
    dpipe[0] = fdiv(div_dividend, div_divisor);
    div_quotient = dpipe[LAT];
  end

  typedef struct { logic [13:0] q; logic [1:0] tag; logic dz; int rdy; } ent_t;
  ent_t             sb[$];
  int               mcyc = 0, mlast = NREQ - 1;
  logic [NREQ-1:0]  exp_ready = '0;
  logic [23:0]      exp_dd = '0, exp_dv = '0;
  logic             exp_rv = 1'b0, exp_dz = 1'b0;
  logic [13:0]      exp_q = '0;
  logic [1:0]       exp_tag = '0;

  // Reference: outstanding results never exceed DEPTH, grants rotate, results in order
  always @(negedge clk) begin
    int g;
    logic [23:0] a, b;
    ent_t e;
    if (!rst_n) begin
      sb.delete();
      mlast = NREQ - 1; mcyc = 0;
      exp_ready = '0; exp_dd = '0; exp_dv = '0; exp_rv = 1'b0;
    end else begin
      exp_rv = (sb.size() > 0) && (sb[0].rdy <= mcyc);
      if (exp_rv) begin exp_q = sb[0].q; exp_tag = sb[0].tag; exp_dz = sb[0].dz; end
      exp_ready = '0; exp_dd = '0; exp_dv = '0; g = -1;
      if (sb.size() < DEPTH)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(mlast + k) % NREQ]) g = (mlast + k) % NREQ;
      if (exp_rv && res_ready) void'(sb.pop_front());
      if (g >= 0) begin
        a = req_dividend[24*g +: 24];
        b = req_divisor[24*g +: 24];
        exp_ready[g] = 1'b1; exp_dd = a; exp_dv = b;
        e.q = (b == 24'd0) ? 14'd0 : fdiv(a, b);
        e.tag = 2'(g); e.dz = (b == 24'd0); e.rdy = mcyc + LAT + 1;
        sb.push_back(e);
        mlast = g;
      end
      mcyc++;
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[24*i +: 24] = 24'($urandom);
      req_divisor[24*i +: 24]  = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0; req_valid = '1; res_ready = 1'b1; rand_ops();
    #2;
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_quotient !== 14'd0) begin n_err++; $display("FAIL rst_res_quotient got %h want 0", res_quotient); end
    n_cmp++; if (res_tag !== 2'd0) begin n_err++; $display("FAIL rst_res_tag got %0d want 0", res_tag); end
    n_cmp++; if (res_dz !== 1'b0) begin n_err++; $display("FAIL rst_res_dz got %b want 0", res_dz); end
    n_cmp++; if (div_dividend !== 24'd0) begin n_err++; $display("FAIL rst_div_dividend got %h want 0", div_dividend); end
    n_cmp++; if (div_divisor !== 24'd0) begin n_err++; $display("FAIL rst_div_divisor got %h want 0", div_divisor); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req_valid = '0;
    @(negedge clk); #1;
    n_cmp++; if ({res_valid, req_ready} !== 5'b0) begin n_err++; $display("FAIL post_rst_idle got %b/%b want 0/0", res_valid, req_ready); end
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    res_ready = 1'b1; req_valid = 4'b0100;
    req_dividend[71:48] = 24'h000800; req_divisor[71:48] = 24'h001000;
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", req_ready); end
    n_cmp++; if ({div_dividend, div_divisor} !== {24'h000800, 24'h001000}) begin n_err++; $display("FAIL single_operands got %h/%h want 000800/001000", div_dividend, div_divisor); end
    @(posedge clk); #1 req_valid = '0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (res_valid) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL single_latency got %0d want 5 (0 = timeout)", lat); end
    n_cmp++; if ({res_quotient, res_tag, res_dz} !== {14'h0800, 2'd2, 1'b0}) begin n_err++; $display("FAIL single_result got q=%h tag=%0d dz=%b want q=0800 tag=2 dz=0", res_quotient, res_tag, res_dz); end
  endtask

  task automatic test_round_robin();
    do_reset();
    res_ready = 1'b1; req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      rand_ops();
      @(negedge clk); #1;
      n_cmp++; if (req_ready !== 4'(1 << (c % 4))) begin n_err++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      n_cmp++; if ({div_dividend, div_divisor} !== {exp_dd, exp_dv}) begin n_err++; $display("FAIL rr_operands c=%0d got %h/%h want %h/%h", c, div_dividend, div_divisor, exp_dd, exp_dv); end
      if (c > LAT) begin
        n_cmp++; if ({res_valid, res_tag} !== {1'b1, 2'((c - LAT - 1) % 4)}) begin n_err++; $display("FAIL rr_result c=%0d got v=%b tag=%0d want v=1 tag=%0d", c, res_valid, res_tag, (c - LAT - 1) % 4); end
        n_cmp++; if ({res_quotient, res_dz} !== {exp_q, exp_dz}) begin n_err++; $display("FAIL rr_data c=%0d got %h/%b want %h/%b", c, res_quotient, res_dz, exp_q, exp_dz); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset();
    res_ready = 1'b0; req_valid = '1; acc = 0;
    for (int c = 0; c < 20; c++) begin
      rand_ops();
      @(negedge clk); #1;
      if (req_ready != '0) acc++;
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL bp_ready c=%0d got %b want %b", c, req_ready, exp_ready); end
      @(posedge clk); #1;
    end
    n_cmp++; if (acc !== DEPTH) begin n_err++; $display("FAIL bp_accept_count got %0d want %0d", acc, DEPTH); end
    res_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL bp_pop_cycle_ready got %b want 0", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== exp_ready || req_ready == 4'b0) begin n_err++; $display("FAIL bp_resume got %b want %b", req_ready, exp_ready); end
  endtask

  task automatic test_divzero();
    logic [13:0] gq [3];
    logic [1:0]  gt [3];
    logic        gd [3];
    int got;
    do_reset();
    res_ready = 1'b1; req_valid = 4'b0111;
    req_dividend[23:0] = 24'h000400; req_divisor[23:0] = 24'h001000;
    req_dividend[47:24] = 24'h123456; req_divisor[47:24] = 24'h000000;
    req_dividend[71:48] = 24'hFFF800; req_divisor[71:48] = 24'h001000;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (res_valid && got < 3) begin gq[got] = res_quotient; gt[got] = res_tag; gd[got] = res_dz; got++; end
    end
    n_cmp++; if (got !== 3) begin n_err++; $display("FAIL dz_count got %0d want 3", got); end
    if (got == 3) begin
      n_cmp++; if ({gq[0], gt[0], gd[0]} !== {14'h0400, 2'd0, 1'b0}) begin n_err++; $display("FAIL dz_before got %h/%0d/%b want 0400/0/0", gq[0], gt[0], gd[0]); end
      n_cmp++; if ({gq[1], gt[1], gd[1]} !== {14'h0000, 2'd1, 1'b1}) begin n_err++; $display("FAIL dz_entry got %h/%0d/%b want 0000/1/1", gq[1], gt[1], gd[1]); end
      n_cmp++; if ({gq[2], gt[2], gd[2]} !== {14'h3800, 2'd2, 1'b0}) begin n_err++; $display("FAIL dz_after got %h/%0d/%b want 3800/2/0", gq[2], gt[2], gd[2]); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = '1; rand_ops();
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk); #1;
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL mid_buffered got %b want 1", res_valid); end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({res_valid, res_quotient, res_tag, res_dz} !== 18'd0) begin n_err++; $display("FAIL mid_async_clear got v=%b q=%h tag=%0d dz=%b want all 0", res_valid, res_quotient, res_tag, res_dz); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req_valid = '1; res_ready = 1'b1; rand_ops();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (c == 0) begin
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
      end
      if (c <= LAT) begin
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale c=%0d got res_valid %b want 0", c, res_valid); end
      end
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL mid_ready c=%0d got %b want %b", c, req_ready, exp_ready); end
      n_cmp++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL mid_res_valid c=%0d got %b want %b", c, res_valid, exp_rv); end
      if (exp_rv) begin
        n_cmp++; if ({res_quotient, res_tag, res_dz} !== {exp_q, exp_tag, exp_dz}) begin n_err++; $display("FAIL mid_result c=%0d got %h/%0d/%b want %h/%0d/%b", c, res_quotient, res_tag, res_dz, exp_q, exp_tag, exp_dz); end
      end
      @(posedge clk); #1 rand_ops();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      req_valid = NREQ'($urandom);
      res_ready = ((c / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      rand_ops();
      @(negedge clk); #1;
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, exp_ready); end
      n_cmp++; if ({div_dividend, div_divisor} !== {exp_dd, exp_dv}) begin n_err++; $display("FAIL rnd_operands c=%0d got %h/%h want %h/%h", c, div_dividend, div_divisor, exp_dd, exp_dv); end
      n_cmp++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL rnd_res_valid c=%0d got %b want %b", c, res_valid, exp_rv); end
      if (exp_rv) begin
        n_cmp++; if ({res_quotient, res_tag, res_dz} !== {exp_q, exp_tag, exp_dz}) begin n_err++; $display("FAIL rnd_result c=%0d got %h/%0d/%b want %h/%0d/%b", c, res_quotient, res_tag, res_dz, exp_q, exp_tag, exp_dz); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_divzero();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one divider instance.
REQ-002 Parameter LAT, 4, fixed divider latency in cycles, operands to quotient.
REQ-003 Parameter DEPTH, 8, result FIFO entries (power of two).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NREQ  per-requester request valid.
REQ-007 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_dividend  in  24*NREQ  signed dividends, requester i at bits [24i+23:24i].
REQ-009 req_divisor  in  24*NREQ  signed divisors, same packing.
REQ-010 div_dividend  out  24  operand to shared divider.
REQ-011 div_divisor  out  24  operand to shared divider.
REQ-012 div_quotient  in  14  signed 1Q12 result from divider, valid LAT cycles after issue.
REQ-013 res_valid  out  1  result FIFO head valid.
REQ-014 res_ready  in  1  consumer accepts head.
REQ-015 res_quotient  out  14  quotient of head entry.
REQ-016 res_tag  out  log2(NREQ)  requester index of head entry.
REQ-017 res_dz  out  1  head entry had divisor == 0.

Function
REQ-018 Issue occurs in a cycle when any req_valid is high and (fifo_count + inflight) < DEPTH; otherwise req_ready is all zero.
REQ-019 Grant is round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on issue.
REQ-020 req_ready[i] is high only in the issue cycle for granted requester i; handshake completes when req_valid[i] and req_ready[i] are both high at the clock edge.
REQ-021 div_dividend/div_divisor are combinationally muxed from the granted requester in the issue cycle, and are 0 when no issue.
REQ-022 A LAT-deep shift register carries {valid, tag, dz} per issue; inflight = number of set valid bits.
REQ-023 When the shift register output valid is set, {div_quotient, tag, dz} is written to the FIFO at that edge; quotient forced to 0 when dz=1.
REQ-024 Request accepted at edge of cycle T is written at end of cycle T+LAT; res_valid rises in cycle T+LAT+1 when FIFO was empty.
REQ-025 FIFO pop occurs when res_valid and res_ready are high; simultaneous push and pop leaves fifo_count unchanged.
REQ-026 Credit check guarantees no push ever meets a full FIFO; overflow is unreachable, and fifo_count never exceeds DEPTH.
REQ-027 Results leave in issue order; one issue and one pop per cycle maximum, sustained throughput one division per cycle when res_ready is held high.
REQ-028 FIFO read/write pointers wrap modulo DEPTH with a separate count; full = count==DEPTH, empty = count==0.
REQ-029 Pop freed in cycle T counts as credit in cycle T+1, not combinationally in cycle T.

Reset
REQ-030 rst_n low asynchronously clears shift register valids, FIFO pointers and count, and sets last_grant = NREQ-1.
REQ-031 During and after reset: req_ready=0, res_valid=0, res_quotient=0, res_tag=0, res_dz=0, div_dividend=0, div_divisor=0.
REQ-032 Reset mid-operation discards all in-flight and buffered results; divider outputs arriving after reset deassertion are ignored because shift register valids are clear.

Verification
REQ-033 Single request: req 2 dividend 0x000800, divisor 0x001000 at cycle 0 -> res_valid in cycle 5, res_quotient 0x0800, res_tag 2, res_dz 0.
REQ-034 All four requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle, results in same order, no gaps after fill.
REQ-035 res_ready=0, all requesters valid -> exactly 8 issues accepted, then req_ready all zero; raising res_ready resumes issue one cycle after first pop.
REQ-036 Divisor 0 from req 1 -> result entry res_tag 1, res_dz 1, res_quotient 0; neighbouring results unaffected.
REQ-037 Assert rst_n low with 3 in flight and 2 buffered -> res_valid 0 immediately; after release no stale results appear, first grant goes to req 0.
REQ-038 Push and pop in same cycle with FIFO holding 8 minus inflight entries -> count unchanged, no loss, no duplication.
